// File: rtl/ifetch_unit.sv
// Instruction fetch stage: sequential PC generation, req/gnt/rvalid memory port,
// prefetch FIFO feeding the decoder, and redirect flush handling.
module ifetch_unit #(
    parameter int unsigned        I_WIDTH    = 32,
    parameter int unsigned        A_WIDTH    = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned        FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_pc,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [I_WIDTH-1:0] imem_rdata,
    output logic               loadInstr,
    output logic [I_WIDTH-1:0] instruction,
    output logic [A_WIDTH-1:0] instr_pc,
    output logic               fetch_err
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] fetch_pc, head_pc;
    logic [CW-1:0]      outstanding, outstanding_nxt, discard, count;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [I_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic               run_en, err;
    logic               redir, misaligned, acc, push, pop, empty, full;
    logic [CW:0]        in_use;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redir      = redirect_valid & (state != HALT);
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign in_use     = (CW+1)'(outstanding) + (CW+1)'(count);
    assign empty      = count == '0;
    assign full       = count == CW'(FIFO_DEPTH);

    // Credits: never request more than the FIFO can absorb; run_en keeps req low through reset.
    assign imem_req  = run_en & (state == RUN) & ~redirect_valid & (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign acc       = imem_req & imem_gnt;

    assign outstanding_nxt = outstanding + CW'(acc) - CW'(imem_rvalid);
    assign push            = imem_rvalid & (discard == '0) & ~redir & (state != HALT);

    assign loadInstr   = (state == RUN) & ~redirect_valid & ~stall & ~empty;
    assign pop         = loadInstr;
    assign instruction = empty ? '0 : fifo_mem[rd_ptr];
    assign instr_pc    = empty ? '0 : head_pc;
    assign fetch_err   = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (redirect_valid) state_nxt = misaligned ? HALT : FLUSH;
            end
            FLUSH: begin
                if (redirect_valid)     state_nxt = misaligned ? HALT : FLUSH;
                else if (discard == '0) state_nxt = RUN;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    // Fetch pointer, credit/discard counters and FIFO control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en      <= 1'b0;
            err         <= 1'b0;
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            run_en      <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redir) begin
                fetch_pc <= redirect_pc;
                head_pc  <= redirect_pc;
                discard  <= outstanding_nxt;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                if (misaligned) err <= 1'b1;
            end else begin
                if (acc) fetch_pc <= fetch_pc + A_WIDTH'(4);
                if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop) begin
                    rd_ptr  <= ptr_inc(rd_ptr);
                    head_pc <= head_pc + A_WIDTH'(4);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= imem_rdata;
    end

    // The credit scheme must never let a response land in a full FIFO without a pop.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule
